// File: rtl/dstack_pkg.sv
// Shared opcode, pointer-delta and FSM definitions for the data-stack front end.
package dstack_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_DROP   = 3'd2;
  localparam logic [2:0] OP_DUP    = 3'd3;
  localparam logic [2:0] OP_SWAP   = 3'd4;
  localparam logic [2:0] OP_OVER   = 3'd5;
  localparam logic [2:0] OP_NIP    = 3'd6;
  localparam logic [2:0] OP_POPREP = 3'd7;

  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_INC  = 2'b01;
  localparam logic [1:0] DELTA_DEC  = 2'b11;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Minimum stack depth (including T) an opcode needs to be legal.
  function automatic logic [1:0] op_min_depth(input logic [2:0] op);
    case (op)
      OP_NOP, OP_PUSH: op_min_depth = 2'd0;
      OP_DROP, OP_DUP: op_min_depth = 2'd1;
      default:         op_min_depth = 2'd2;
    endcase
  endfunction

  function automatic logic op_grows(input logic [2:0] op);
    op_grows = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

endpackage

// File: rtl/dstack_ctrl.sv
// Data-stack front end: T register, depth tracking and store pointer control.
// One op per cycle when op_ready; after reset the store pointers are drained to zero.
module dstack_ctrl
  import dstack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DW-1:0]    depth,
  output logic             err,
  output logic             underflow,
  output logic             overflow,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic [WIDTH-1:0] stk_rd
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_END = DW'(DEPTH - 1);
  localparam logic [DW-1:0] ONE       = DW'(1);

  state_e           state_q;
  logic [DW-1:0]    drain_q;
  logic             op_ready_q;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic             byp_q, byp_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             uf_q, uf_d;
  logic             of_q, of_d;

  logic             accept;
  logic             too_shallow;
  logic             too_deep;
  logic [WIDTH-1:0] nos_cur;

  assign op_ready    = op_ready_q && !rst;
  assign accept      = op_valid && op_ready;
  assign too_shallow = depth_q < DW'(op_min_depth(op));
  assign too_deep    = op_grows(op) && (depth_q == DEPTH_MAX);
  assign nos_cur     = byp_q ? nos_q : stk_rd;

  // Drain walks the store pointer down DEPTH times so it saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      drain_q    <= '0;
      op_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (drain_q == DRAIN_END) begin
            state_q    <= ST_RUN;
            op_ready_q <= 1'b1;
          end else begin
            drain_q <= drain_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tos_d     = tos_q;
    nos_d     = nos_q;
    byp_d     = byp_q;
    depth_d   = depth_q;
    err_d     = 1'b0;
    uf_d      = uf_q;
    of_d      = of_q;
    stk_we    = 1'b0;
    stk_delta = DELTA_HOLD;
    if (rst || state_q == ST_INIT) begin
      stk_delta = DELTA_DEC;
    end else if (accept) begin
      if (too_shallow || too_deep) begin
        err_d = 1'b1;
        if (too_shallow) uf_d = 1'b1;
        else             of_d = 1'b1;
      end else begin
        case (op)
          OP_PUSH, OP_DUP: begin
            // An empty stack has nothing to spill: T is simply loaded.
            if (depth_q != '0) begin
              stk_we    = 1'b1;
              stk_delta = DELTA_INC;
            end
            tos_d   = (op == OP_PUSH) ? op_data : tos_q;
            nos_d   = tos_q;
            byp_d   = 1'b1;
            depth_d = depth_q + ONE;
          end
          OP_DROP: begin
            if (depth_q == ONE) begin
              tos_d = '0;
            end else begin
              stk_delta = DELTA_DEC;
              tos_d     = nos_cur;
            end
            byp_d   = 1'b0;
            depth_d = depth_q - ONE;
          end
          OP_SWAP: begin
            stk_we = 1'b1;
            tos_d  = nos_cur;
            nos_d  = tos_q;
            byp_d  = 1'b1;
          end
          OP_OVER: begin
            stk_we    = 1'b1;
            stk_delta = DELTA_INC;
            tos_d     = nos_cur;
            nos_d     = tos_q;
            byp_d     = 1'b1;
            depth_d   = depth_q + ONE;
          end
          OP_NIP, OP_POPREP: begin
            stk_delta = DELTA_DEC;
            if (op == OP_POPREP) tos_d = op_data;
            byp_d   = 1'b0;
            depth_d = depth_q - ONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q   <= '0;
      nos_q   <= '0;
      byp_q   <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      byp_q   <= byp_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  assign tos       = tos_q;
  assign nos       = nos_cur;
  assign depth     = depth_q;
  assign err       = err_q;
  assign underflow = uf_q;
  assign overflow  = of_q;
  assign stk_wd    = tos_q;

endmodule
